// File: rtl/tx_pkg.sv
// Shared link definitions for the serial transmitter and its receiver partner.
//   `HDR_SZ, `PL_SZ, `ADDR_SZ : flit field widths (overridable before this file)
//   `FLIT_W                   : total flit width, used by both tx and rx
// Package tx_pkg:
//   FLIT_W     : flit width as an elaboration constant
//   CNT_W      : bit-counter width, wide enough to hold FLIT_W
//   tx_state_e : transmitter FSM states
`ifndef LINK_DEFINES_SV
`define LINK_DEFINES_SV

`ifndef HDR_SZ
`define HDR_SZ 2
`endif

`ifndef PL_SZ
`define PL_SZ 4
`endif

`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

`define FLIT_W (`HDR_SZ + `PL_SZ + `ADDR_SZ)

`endif

package tx_pkg;

  localparam int unsigned FLIT_W = `FLIT_W;
  localparam int unsigned CNT_W  = $clog2(FLIT_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SEND = 2'd2
  } tx_state_e;

endpackage

// File: rtl/tx.sv
// Serial link transmitter. Latches one flit from the router output buffer
// and sends it LSB first behind a single high head bit; a frame is never
// started while the downstream receiver reports channel_busy.
// Ports:
//   clk          : clock
//   reset        : asynchronous, active-high reset
//   valid        : upstream buffer holds a flit on parallel_in
//   parallel_in  : flit to send (FLIT_W bits)
//   item_read    : one-cycle pulse, flit on parallel_in consumed this cycle
//   channel_busy : downstream rx is receiving or holding an undelivered flit
//   serial_out   : registered serial line, idle level 0
//   busy         : tx holds or is sending a flit
module tx
  import tx_pkg::*;
#(
  parameter int    routerid = -1,
  parameter string port     = "unknown"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [FLIT_W-1:0] parallel_in,
  output logic              item_read,
  input  logic              channel_busy,
  output logic              serial_out,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLIT_W);

  // routerid and port only label this instance; -1 means unlabelled.
  if (routerid < -1) begin : g_bad_routerid
    $error("tx %s: routerid must be -1 or a router index", port);
  end

  tx_state_e         state_q, state_d;
  logic [FLIT_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              serial_out_q, serial_out_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      serial_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      serial_out_q <= serial_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    serial_out_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          shreg_d = parallel_in;
          state_d = ARM;
        end
      end
      ARM: begin
        // Head goes out only once the receiver is free; wait indefinitely.
        if (!channel_busy) begin
          serial_out_d = 1'b1;
          cnt_d        = '0;
          state_d      = SEND;
        end
      end
      SEND: begin
        // channel_busy is ignored here: a head is always followed by FLIT_W bits.
        if (cnt_q < CNT_LAST) begin
          serial_out_d = shreg_q[0];
          shreg_d      = shreg_q >> 1;
          cnt_d        = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign item_read  = (state_q == IDLE) && valid;
  assign busy       = (state_q != IDLE);
  assign serial_out = serial_out_q;

endmodule

// File: tb/tb_tx.sv
`timescale 1ns/1ps
module tb_tx;

  localparam int unsigned W = `FLIT_W;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [W-1:0] parallel_in;
  logic         item_read;
  logic         channel_busy;
  logic         serial_out;
  logic         busy;

  logic         loopback;
  logic         cb_drv;

  int           tests  = 0;
  int           failed = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_flit;

  tx #(.routerid(0), .port("east")) dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .parallel_in  (parallel_in),
    .item_read    (item_read),
    .channel_busy (channel_busy),
    .serial_out   (serial_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural link receiver: waits for the head, shifts W bits LSB first,
  // samples the trailing slot, then holds the flit until read 3 cycles later.
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_TRAIL, R_HOLD} rx_state_e;
  rx_state_e    rx_state;
  logic [W-1:0] rx_data;
  int unsigned  rx_idx;
  int unsigned  rx_hold;
  logic         rx_trail;
  logic         rx_busy;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= R_IDLE;
      rx_data  <= '0;
      rx_idx   <= 0;
      rx_hold  <= 0;
      rx_trail <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: if (serial_out) begin
          rx_state <= R_DATA;
          rx_idx   <= 0;
        end
        R_DATA: begin
          rx_data[rx_idx] <= serial_out;
          if (rx_idx == W - 1) rx_state <= R_TRAIL;
          else rx_idx <= rx_idx + 1;
        end
        R_TRAIL: begin
          rx_trail <= serial_out;
          rx_hold  <= 0;
          rx_state <= R_HOLD;
        end
        default: begin
          if (rx_hold == 3) rx_state <= R_IDLE;
          else rx_hold <= rx_hold + 1;
        end
      endcase
    end
  end

  assign rx_busy      = (rx_state != R_IDLE);
  assign channel_busy = loopback ? rx_busy : cb_drv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each flit presented by the receiver is checked
  // against the oldest flit latched by the stimulus.
  always @(negedge clk) begin
    if (!reset && rx_state == R_HOLD && rx_hold == 0) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL rx_unexpected: got flit %0h expected none at %0t", rx_data, $time);
      end else begin
        exp_flit = exp_q.pop_front();
        chk("rx_flit", 32'(rx_data), 32'(exp_flit));
        chk("rx_trail", 32'(rx_trail), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 0);
    repeat (8) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  seq_a5;
    logic [7:0]  seq_3c;
    logic [7:0]  seq_c3;
    int unsigned cyc;
    logic        found;
    logic        prev_cb;

    seq_a5 = 10'b1101001010;  // head, A5 LSB first, trailing 0
    seq_3c = 8'b00111100;     // 3C LSB first
    seq_c3 = 8'b11000011;     // C3 LSB first

    reset = 1'b1; valid = 1'b0; parallel_in = '0; cb_drv = 1'b0; loopback = 1'b0;
    repeat (3) tick();
    chk("rst_serial", 32'(serial_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_item_read", 32'(item_read), 0);
    reset = 1'b0;

    // Idle: nothing happens without valid.
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      chk("idle_serial", 32'(serial_out), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_item_read", 32'(item_read), 0);
    end

    // Single frame, minimum latency.
    tick();
    valid = 1'b1; parallel_in = 8'hA5; exp_q.push_back(8'hA5);
    #1;
    chk("a5_item_read_c0", 32'(item_read), 1);
    tick();
    valid = 1'b0;
    #1;
    chk("a5_item_read_c1", 32'(item_read), 0);
    chk("a5_busy_c1", 32'(busy), 1);
    chk("a5_serial_c1", 32'(serial_out), 0);
    for (int unsigned k = 2; k <= 11; k++) begin
      tick();
      chk("a5_serial_bit", 32'(serial_out), 32'(seq_a5[11 - k]));
      if (k == 10) chk("a5_busy_c10", 32'(busy), 1);
    end
    tick();
    chk("a5_busy_c12", 32'(busy), 0);
    drain();

    // Receiver busy holds tx in ARM; busy during SEND is ignored.
    tick();
    valid = 1'b1; parallel_in = 8'h3C; cb_drv = 1'b1; exp_q.push_back(8'h3C);
    #1;
    chk("3c_item_read", 32'(item_read), 1);
    for (int unsigned c = 1; c <= 5; c++) begin
      tick();
      valid = 1'b0;
      #1;
      chk("3c_arm_serial", 32'(serial_out), 0);
      chk("3c_arm_busy", 32'(busy), 1);
      chk("3c_arm_item_read", 32'(item_read), 0);
    end
    tick();
    cb_drv = 1'b0;
    chk("3c_release_serial", 32'(serial_out), 0);
    tick();
    chk("3c_head", 32'(serial_out), 1);
    cb_drv = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      chk("3c_serial_bit", 32'(serial_out), 32'(seq_3c[7 - i]));
    end
    tick();
    chk("3c_trail", 32'(serial_out), 0);
    cb_drv = 1'b0;
    drain();

    // Loopback: two back-to-back flits gated by the receiver's channel_busy.
    loopback = 1'b1;
    cyc = 0;
    tick();
    valid = 1'b1; parallel_in = 8'h01; exp_q.push_back(8'h01);
    #1;
    chk("lb_item_read_c0", 32'(item_read), 1);
    tick();
    cyc = 1;
    parallel_in = 8'hFF;
    found = 1'b0;
    for (int unsigned n = 0; n < 40 && !found; n++) begin
      tick();
      cyc++;
      if (item_read) found = 1'b1;
    end
    chk("lb_second_latch_seen", 32'(found), 1);
    chk("lb_second_latch_cycle", cyc, 11);
    if (found) exp_q.push_back(8'hFF);
    prev_cb = channel_busy;
    tick();
    cyc++;
    valid = 1'b0;
    #1;
    found = 1'b0;
    for (int unsigned n = 0; n < 40 && !found; n++) begin
      if (serial_out) begin
        found = 1'b1;
      end else begin
        prev_cb = channel_busy;
        tick();
        cyc++;
      end
    end
    chk("lb_second_head_seen", 32'(found), 1);
    chk("lb_second_head_cycle", cyc, 17);
    chk("lb_cb_before_head", 32'(prev_cb), 0);
    drain();

    // Reset in the fifth SEND cycle aborts the frame; the next one is clean.
    tick();
    valid = 1'b1; parallel_in = 8'h99;
    #1;
    chk("abort_item_read", 32'(item_read), 1);
    tick();
    valid = 1'b0;
    repeat (5) tick();
    chk("abort_busy_pre", 32'(busy), 1);
    chk("abort_serial_pre", 32'(serial_out), 1);
    reset = 1'b1;
    #1;
    chk("abort_serial", 32'(serial_out), 0);
    chk("abort_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_serial_after", 32'(serial_out), 0);
    valid = 1'b1; parallel_in = 8'h5A; exp_q.push_back(8'h5A);
    #1;
    chk("5a_item_read", 32'(item_read), 1);
    tick();
    valid = 1'b0;
    drain();

    // parallel_in changes after latching do not reach the line.
    tick();
    valid = 1'b1; parallel_in = 8'hC3; exp_q.push_back(8'hC3);
    #1;
    chk("c3_item_read", 32'(item_read), 1);
    tick();
    valid = 1'b0; parallel_in = 8'h00;
    tick();
    chk("c3_head", 32'(serial_out), 1);
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      chk("c3_serial_bit", 32'(serial_out), 32'(seq_c3[7 - i]));
    end
    tick();
    chk("c3_trail", 32'(serial_out), 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
